// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: pipeline interlock for the 19-bit MIPS core.
// Stalls on load-use, flushes on taken branch, freezes for data memory.
module hazard_stall_unit #(
    parameter int MEM_WAIT_CYCLES = 2,
    parameter int COUNT_W         = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [18:0]        ID_inst,
    input  logic               ID_reg2_read_source,
    input  logic [18:0]        EX_inst,
    input  logic               EX_mem_read,
    input  logic               EX_branch_taken,
    input  logic               MEM_mem_access,
    output logic               pc_write,
    output logic               IF_ID_write,
    output logic               IF_ID_flush,
    output logic               ID_EX_bubble,
    output logic               EX_MEM_write,
    output logic               MEM_WB_bubble,
    output logic [COUNT_W-1:0] stall_cycles,
    output logic [COUNT_W-1:0] flush_count
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] WAIT_LOAD =
        (MEM_WAIT_CYCLES >= 2) ? 4'(MEM_WAIT_CYCLES - 2) : 4'd0;
    localparam logic MEM_SLOW = (MEM_WAIT_CYCLES != 0);
    localparam logic ONE_WAIT = (MEM_WAIT_CYCLES == 1);
    localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

    logic [1:0] state;
    logic [3:0] cnt;
    logic [2:0] ex_dest;
    logic [2:0] id_src1;
    logic [2:0] id_src2;
    logic       load_use;
    logic       freeze;
    logic       m_rst;
    logic       m_frz;
    logic       m_br;
    logic       m_lu;
    logic       unused_bits;

    assign ex_dest = EX_inst[13:11];
    assign id_src1 = ID_inst[10:8];
    assign id_src2 = ID_reg2_read_source ? ID_inst[10:8] : ID_inst[7:5];

    assign load_use = EX_mem_read && (ex_dest != 3'd0) &&
                      ((ex_dest == id_src1) || (ex_dest == id_src2));

    assign freeze = (state == ST_RUN && MEM_mem_access && MEM_SLOW) ||
                    (state == ST_WAIT);

    // One-hot action select; earlier terms mask later ones.
    assign m_rst = rst;
    assign m_frz = !rst && freeze;
    assign m_br  = !rst && !freeze && EX_branch_taken;
    assign m_lu  = !rst && !freeze && !EX_branch_taken && load_use;

    assign unused_bits = ^{ID_inst[18:11], ID_inst[4:0],
                           EX_inst[18:14], EX_inst[10:0]};

    // Pipeline-register enables and bubble selects for the chosen action.
    always_comb begin
        pc_write      = 1'b1;
        IF_ID_write   = 1'b1;
        IF_ID_flush   = 1'b0;
        ID_EX_bubble  = 1'b0;
        EX_MEM_write  = 1'b1;
        MEM_WB_bubble = 1'b0;
        unique case (1'b1)
            m_rst: begin
                pc_write      = 1'b0;
                IF_ID_write   = 1'b0;
                IF_ID_flush   = 1'b1;
                ID_EX_bubble  = 1'b1;
                EX_MEM_write  = 1'b0;
                MEM_WB_bubble = 1'b1;
            end
            m_frz: begin
                pc_write      = 1'b0;
                IF_ID_write   = 1'b0;
                EX_MEM_write  = 1'b0;
                MEM_WB_bubble = 1'b1;
            end
            m_br: begin
                IF_ID_flush  = 1'b1;
                ID_EX_bubble = 1'b1;
            end
            m_lu: begin
                pc_write     = 1'b0;
                IF_ID_write  = 1'b0;
                ID_EX_bubble = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Memory freeze sequencer: RUN -> WAIT (countdown) -> DONE -> RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
            cnt   <= 4'd0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (freeze) begin
                        if (ONE_WAIT) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= WAIT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) state <= ST_DONE;
                    else             cnt   <= cnt - 4'd1;
                end
                ST_DONE: state <= ST_RUN;
                default: state <= ST_RUN;
            endcase
        end
    end

    // Saturating counts of stalled cycles and branch flushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_write && stall_cycles != '1)
                stall_cycles <= stall_cycles + CNT_ONE;
            if (IF_ID_flush && flush_count != '1)
                flush_count <= flush_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: table vectors plus freeze/branch/reset sequences
// across four parameterisations sharing one stimulus.
module tb_hazard_stall_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [18:0] id_inst;
    logic        rs;
    logic [18:0] ex_inst;
    logic        mr;
    logic        br;
    logic        ma;

    logic [5:0]  o0, o1, o2, o3;
    logic [15:0] sc0, fc0, sc1, fc1, sc2, fc2;
    logic [3:0]  sc3, fc3;

    always #5 clk = ~clk;

    // {pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, EX_MEM_write, MEM_WB_bubble}
    localparam logic [5:0] RUNV = 6'b110010;
    localparam logic [5:0] FRZ  = 6'b000001;
    localparam logic [5:0] BRV  = 6'b111110;
    localparam logic [5:0] LU   = 6'b000110;
    localparam logic [5:0] RSTV = 6'b001101;
    localparam logic [18:0] Z   = 19'd0;

    hazard_stall_unit #(.MEM_WAIT_CYCLES(0), .COUNT_W(16)) u0 (
        .clk(clk), .rst(rst), .ID_inst(id_inst), .ID_reg2_read_source(rs),
        .EX_inst(ex_inst), .EX_mem_read(mr), .EX_branch_taken(br),
        .MEM_mem_access(ma), .pc_write(o0[5]), .IF_ID_write(o0[4]),
        .IF_ID_flush(o0[3]), .ID_EX_bubble(o0[2]), .EX_MEM_write(o0[1]),
        .MEM_WB_bubble(o0[0]), .stall_cycles(sc0), .flush_count(fc0));

    hazard_stall_unit #(.MEM_WAIT_CYCLES(1), .COUNT_W(16)) u1 (
        .clk(clk), .rst(rst), .ID_inst(id_inst), .ID_reg2_read_source(rs),
        .EX_inst(ex_inst), .EX_mem_read(mr), .EX_branch_taken(br),
        .MEM_mem_access(ma), .pc_write(o1[5]), .IF_ID_write(o1[4]),
        .IF_ID_flush(o1[3]), .ID_EX_bubble(o1[2]), .EX_MEM_write(o1[1]),
        .MEM_WB_bubble(o1[0]), .stall_cycles(sc1), .flush_count(fc1));

    hazard_stall_unit #(.MEM_WAIT_CYCLES(2), .COUNT_W(16)) u2 (
        .clk(clk), .rst(rst), .ID_inst(id_inst), .ID_reg2_read_source(rs),
        .EX_inst(ex_inst), .EX_mem_read(mr), .EX_branch_taken(br),
        .MEM_mem_access(ma), .pc_write(o2[5]), .IF_ID_write(o2[4]),
        .IF_ID_flush(o2[3]), .ID_EX_bubble(o2[2]), .EX_MEM_write(o2[1]),
        .MEM_WB_bubble(o2[0]), .stall_cycles(sc2), .flush_count(fc2));

    hazard_stall_unit #(.MEM_WAIT_CYCLES(8), .COUNT_W(4)) u3 (
        .clk(clk), .rst(rst), .ID_inst(id_inst), .ID_reg2_read_source(rs),
        .EX_inst(ex_inst), .EX_mem_read(mr), .EX_branch_taken(br),
        .MEM_mem_access(ma), .pc_write(o3[5]), .IF_ID_write(o3[4]),
        .IF_ID_flush(o3[3]), .ID_EX_bubble(o3[2]), .EX_MEM_write(o3[1]),
        .MEM_WB_bubble(o3[0]), .stall_cycles(sc3), .flush_count(fc3));

    typedef struct {
        string       name;
        logic        rst;
        logic [18:0] id;
        logic        rs;
        logic [18:0] ex;
        logic        mr;
        logic        br;
        logic        ma;
        logic [5:0]  outs;
        int          stall;
        int          flush;
    } vec_t;

    typedef struct {
        string      name;
        int         inst;
        logic [5:0] outs;
        int         stall;
        int         flush;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[12];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [18:0] mk(logic [2:0] d, logic [2:0] s1,
                                       logic [2:0] s2);
        return {5'd0, d, s1, s2, 5'd0};
    endfunction

    function automatic logic [5:0] get_o(int k);
        case (k)
            0: return o0;
            1: return o1;
            2: return o2;
            default: return o3;
        endcase
    endfunction

    function automatic int get_s(int k);
        case (k)
            0: return int'(sc0);
            1: return int'(sc1);
            2: return int'(sc2);
            default: return int'(sc3);
        endcase
    endfunction

    function automatic int get_f(int k);
        case (k)
            0: return int'(fc0);
            1: return int'(fc1);
            2: return int'(fc2);
            default: return int'(fc3);
        endcase
    endfunction

    task automatic drive(input logic r, input logic [18:0] id,
                         input logic s, input logic [18:0] ex,
                         input logic m, input logic b, input logic a);
        @(posedge clk);
        #1;
        rst = r; id_inst = id; rs = s; ex_inst = ex;
        mr = m; br = b; ma = a;
    endtask

    task automatic expect_o(input string nm, input int k,
                            input logic [5:0] o,
                            input int st = -1, input int fl = -1);
        exp_t e;
        e.name = nm; e.inst = k; e.outs = o; e.stall = st; e.flush = fl;
        sb.push_back(e);
    endtask

    task automatic check_all();
        exp_t e;
        @(negedge clk);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            n_tests++;
            if (get_o(e.inst) !== e.outs) begin
                n_fail++;
                $display("FAIL %s u%0d outs got %b want %b",
                         e.name, e.inst, get_o(e.inst), e.outs);
            end
            if (e.stall >= 0) begin
                n_tests++;
                if (get_s(e.inst) != e.stall) begin
                    n_fail++;
                    $display("FAIL %s u%0d stall_cycles got %0d want %0d",
                             e.name, e.inst, get_s(e.inst), e.stall);
                end
            end
            if (e.flush >= 0) begin
                n_tests++;
                if (get_f(e.inst) != e.flush) begin
                    n_fail++;
                    $display("FAIL %s u%0d flush_count got %0d want %0d",
                             e.name, e.inst, get_f(e.inst), e.flush);
                end
            end
        end
    endtask

    task automatic reset_all();
        drive(1'b1, Z, 1'b0, Z, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) expect_o("rst", k, RSTV);
        check_all();
    endtask

    initial begin
        rst = 1'b1; id_inst = Z; rs = 1'b0; ex_inst = Z;
        mr = 1'b0; br = 1'b0; ma = 1'b0;

        vecs[0]  = '{"rst0",   1'b1, Z,           1'b0, Z,           1'b0, 1'b0, 1'b0, RSTV, -1, -1};
        vecs[1]  = '{"rst1",   1'b1, Z,           1'b0, Z,           1'b0, 1'b0, 1'b0, RSTV,  0,  0};
        vecs[2]  = '{"idle",   1'b0, Z,           1'b0, Z,           1'b0, 1'b0, 1'b0, RUNV,  0,  0};
        vecs[3]  = '{"lu_s1",  1'b0, mk(0,3,0),   1'b0, mk(3,0,0),   1'b1, 1'b0, 1'b0, LU,    0,  0};
        vecs[4]  = '{"after",  1'b0, Z,           1'b0, Z,           1'b0, 1'b0, 1'b0, RUNV,  1,  0};
        vecs[5]  = '{"dest0",  1'b0, mk(0,0,0),   1'b0, mk(0,0,0),   1'b1, 1'b0, 1'b0, RUNV,  1,  0};
        vecs[6]  = '{"src2hi", 1'b0, mk(0,2,5),   1'b1, mk(5,0,0),   1'b1, 1'b0, 1'b0, RUNV,  1,  0};
        vecs[7]  = '{"src2lo", 1'b0, mk(0,2,5),   1'b0, mk(5,0,0),   1'b1, 1'b0, 1'b0, LU,    1,  0};
        vecs[8]  = '{"br_lu",  1'b0, mk(0,3,0),   1'b0, mk(3,0,0),   1'b1, 1'b1, 1'b0, BRV,   2,  0};
        vecs[9]  = '{"idle2",  1'b0, Z,           1'b0, Z,           1'b0, 1'b0, 1'b0, RUNV,  2,  1};
        vecs[10] = '{"lu_s2",  1'b0, mk(0,1,2),   1'b0, mk(2,0,0),   1'b1, 1'b0, 1'b0, LU,    2,  1};
        vecs[11] = '{"idle3",  1'b0, Z,           1'b0, Z,           1'b0, 1'b0, 1'b0, RUNV,  3,  1};

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].rst, vecs[i].id, vecs[i].rs, vecs[i].ex,
                  vecs[i].mr, vecs[i].br, vecs[i].ma);
            expect_o(vecs[i].name, 2, vecs[i].outs,
                     vecs[i].stall, vecs[i].flush);
            check_all();
        end

        // Memory freeze across wait depths 0/1/2/8, access held c0..c3.
        reset_all();
        drive(1'b0, Z, 1'b0, Z, 1'b0, 1'b0, 1'b1);
        expect_o("frz_c0", 0, RUNV, 0, 0);
        expect_o("frz_c0", 1, FRZ, 0, 0);
        expect_o("frz_c0", 2, FRZ, 0, 0);
        expect_o("frz_c0", 3, FRZ, 0, 0);
        check_all();
        drive(1'b0, Z, 1'b0, Z, 1'b0, 1'b0, 1'b1);
        expect_o("frz_c1", 0, RUNV);
        expect_o("frz_c1", 1, RUNV);
        expect_o("frz_c1", 2, FRZ);
        expect_o("frz_c1", 3, FRZ);
        check_all();
        drive(1'b0, Z, 1'b0, Z, 1'b0, 1'b0, 1'b1);
        expect_o("frz_c2", 0, RUNV);
        expect_o("frz_c2", 1, FRZ);
        expect_o("frz_c2", 2, RUNV);
        expect_o("frz_c2", 3, FRZ);
        check_all();
        drive(1'b0, Z, 1'b0, Z, 1'b0, 1'b0, 1'b1);
        expect_o("frz_c3", 0, RUNV);
        expect_o("frz_c3", 1, RUNV);
        expect_o("frz_c3", 2, FRZ);
        expect_o("frz_c3", 3, FRZ);
        check_all();
        drive(1'b0, Z, 1'b0, Z, 1'b0, 1'b0, 1'b0);
        expect_o("frz_c4", 1, RUNV);
        expect_o("frz_c4", 2, FRZ);
        expect_o("frz_c4", 3, FRZ);
        check_all();
        drive(1'b0, Z, 1'b0, Z, 1'b0, 1'b0, 1'b0);
        expect_o("frz_c5", 0, RUNV, 0, 0);
        expect_o("frz_c5", 1, RUNV, 2, 0);
        expect_o("frz_c5", 2, RUNV, 4, 0);
        expect_o("frz_c5", 3, FRZ, 5, 0);
        check_all();

        // Taken branch held during a freeze: one flush on release.
        reset_all();
        drive(1'b0, Z, 1'b0, Z, 1'b0, 1'b1, 1'b1);
        expect_o("brf_c0", 2, FRZ, 0, 0);
        expect_o("brf_c0", 3, FRZ, 0, 0);
        check_all();
        drive(1'b0, Z, 1'b0, Z, 1'b0, 1'b1, 1'b0);
        expect_o("brf_c1", 2, FRZ, 1, 0);
        check_all();
        drive(1'b0, Z, 1'b0, Z, 1'b0, 1'b1, 1'b0);
        expect_o("brf_c2", 2, BRV, 2, 0);
        expect_o("brf_c2", 3, FRZ, 2, 0);
        check_all();
        drive(1'b0, Z, 1'b0, Z, 1'b0, 1'b0, 1'b0);
        expect_o("brf_c3", 2, RUNV, 2, 1);
        expect_o("brf_c3", 3, FRZ, 3, 0);
        check_all();

        // Reset on the third frozen cycle of an 8-cycle wait.
        reset_all();
        drive(1'b0, Z, 1'b0, Z, 1'b0, 1'b0, 1'b1);
        expect_o("rw_c0", 3, FRZ, 0, 0);
        check_all();
        drive(1'b0, Z, 1'b0, Z, 1'b0, 1'b0, 1'b0);
        expect_o("rw_c1", 3, FRZ, 1, 0);
        check_all();
        drive(1'b1, Z, 1'b0, Z, 1'b0, 1'b0, 1'b0);
        expect_o("rw_rst", 3, RSTV, 2, 0);
        check_all();
        drive(1'b0, Z, 1'b0, Z, 1'b0, 1'b0, 1'b0);
        expect_o("rw_c3", 3, RUNV, 0, 0);
        check_all();
        drive(1'b0, Z, 1'b0, Z, 1'b0, 1'b0, 1'b0);
        expect_o("rw_c4", 3, RUNV, 0, 0);
        check_all();

        // Saturation of the 4-bit stall counter.
        reset_all();
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, mk(0,3,0), 1'b0, mk(3,0,0), 1'b1, 1'b0, 1'b0);
            expect_o("sat", 3, LU, (i > 15) ? 15 : i, 0);
            check_all();
        end
        drive(1'b0, Z, 1'b0, Z, 1'b0, 1'b0, 1'b0);
        expect_o("sat_end", 3, RUNV, 15, 0);
        check_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Pipeline interlock controller for the 19-bit-instruction MIPS pipeline: resolves the hazards that bypassing cannot, by stalling and flushing instead of forwarding. Detects load-use dependences in ID, flushes wrong-path instructions on a taken branch resolved in EX, and freezes the pipeline for a fixed number of cycles while the data memory services a MEM-stage access. Drives the write enables and bubble selects of the PC and the pipeline registers, and keeps saturating stall and flush counters.

## Interface
- MEM_WAIT_CYCLES, 2, total freeze cycles per MEM-stage data access; legal range 0..15; 0 = single-cycle memory.
- COUNT_W, 16, width of the performance counters.

- clk  input  1  pipeline clock
- rst  input  1  synchronous, active-high reset
- ID_inst  input  19  instruction in ID; [10:8] = src1, [7:5] = src2
- ID_reg2_read_source  input  1  1: second read port uses [10:8]; 0: uses [7:5]
- EX_inst  input  19  instruction in EX; [13:11] = dest
- EX_mem_read  input  1  EX instruction is a load
- EX_branch_taken  input  1  branch in EX resolved taken
- MEM_mem_access  input  1  MEM instruction reads or writes data memory
- pc_write  output  1  PC load enable
- IF_ID_write  output  1  IF/ID load enable
- IF_ID_flush  output  1  IF/ID loads a NOP
- ID_EX_bubble  output  1  ID/EX loads a NOP
- EX_MEM_write  output  1  EX/MEM load enable
- MEM_WB_bubble  output  1  MEM/WB loads a NOP
- stall_cycles  output  COUNT_W  cycles with pc_write=0, saturating
- flush_count  output  COUNT_W  taken-branch flushes, saturating

## Operation
- Register 0 is hardwired; dest 3'b000 never creates a hazard.
- src2 = ID_reg2_read_source ? ID_inst[10:8] : ID_inst[7:5].
- load_use = EX_mem_read & EX_inst[13:11]!=0 & (EX_inst[13:11]==ID_inst[10:8] | EX_inst[13:11]==src2).
- States: RUN, WAIT, DONE. Registered: state, 4-bit cnt, both counters.
- freeze = (state==RUN & MEM_mem_access & MEM_WAIT_CYCLES!=0) | state==WAIT.
- Transitions:
  - RUN with freeze: to DONE if MEM_WAIT_CYCLES==1; else to WAIT, cnt <= MEM_WAIT_CYCLES-2.
  - WAIT: cnt==0 -> DONE; else cnt <= cnt-1.
  - DONE -> RUN unconditionally. MEM_mem_access is ignored in DONE, since the access completes that cycle.
- Output priority:
  - freeze: pc_write=0, IF_ID_write=0, EX_MEM_write=0, MEM_WB_bubble=1, IF_ID_flush=0, ID_EX_bubble=0. All of ID/EX, EX/MEM and the branch are held; branch and load-use actions are deferred.
  - else EX_branch_taken: pc_write=1, IF_ID_flush=1, ID_EX_bubble=1, IF_ID_write=1, EX_MEM_write=1. load_use is ignored, because the ID instruction is discarded.
  - else load_use: pc_write=0, IF_ID_write=0, ID_EX_bubble=1, EX_MEM_write=1.
  - else: pc_write=1, IF_ID_write=1, EX_MEM_write=1, all bubbles/flush 0.
- Counters:
  - stall_cycles += 1 on every non-reset cycle with pc_write=0.
  - flush_count += 1 on every non-reset cycle with IF_ID_flush=1.
  - Both hold at all-ones.

## Timing
- Outputs are combinational from registered state and current inputs; hazard action takes effect in the detection cycle.
- A MEM access gives exactly MEM_WAIT_CYCLES consecutive frozen cycles. The release cycle (DONE) advances the pipeline.
- Load-use stall lasts 1 cycle unless extended by a freeze.
- Back-to-back accesses: after DONE, a new MEM instruction in RUN starts a new freeze immediately.
- Reset, while rst=1: pc_write=0, IF_ID_write=0, EX_MEM_write=0, IF_ID_flush=1, ID_EX_bubble=1, MEM_WB_bubble=1, counters not incremented.
- Reset, next edge: state=RUN, cnt=0, stall_cycles=0, flush_count=0.
- rst mid-WAIT aborts the wait; no residual freeze after rst falls.

## Test plan
- Load-use: EX_mem_read=1, EX dest=3, ID src1=3 -> one cycle pc_write=0, IF_ID_write=0, ID_EX_bubble=1; stall_cycles 0→1. Repeat with dest=0 -> no stall.
- src2 select: EX load dest=5, ID [7:5]=5, [10:8]=2, ID_reg2_read_source=1 -> no stall; ID_reg2_read_source=0 -> stall.
- Memory freeze, MEM_WAIT_CYCLES=2: MEM_mem_access held high from c0 -> freeze in c0 and c1 (MEM_WB_bubble=1), released in c2. A new access in c3 -> freeze again. Repeat with 0 -> never freezes; with 1 -> freeze c0 only.
- Branch vs load-use, same cycle: EX_branch_taken=1 with load_use=1 -> IF_ID_flush=1, ID_EX_bubble=1, pc_write=1; flush_count +1; stall_cycles unchanged.
- Branch during freeze: EX_branch_taken=1 during WAIT -> no flush until the DONE cycle, then a single flush.
- Reset mid-WAIT (MEM_WAIT_CYCLES=8, rst at 3rd frozen cycle) -> reset output values while rst=1; counters 0, RUN, no freeze after rst falls with MEM_mem_access=0. Saturation: preload 2^COUNT_W-1 stalls (COUNT_W=4) -> stall_cycles holds 15.
